// File: rtl/nios_pio_arb_pkg.sv
// Shared types and constants for the two-requester PIO arbiter.
package nios_pio_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_HW  = 1'b1;

    // Reset to HW so the CPU wins the first contention.
    localparam logic LAST_GRANT_RST = REQ_HW;

endpackage

// File: rtl/nios_pio_arbiter_rr_arb2.sv
// Combinational 2-way round-robin grant; the last-grant register lives in the parent.
module rr_arb2
    import nios_pio_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (last_grant_i == REQ_CPU) ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/nios_pio_arbiter.sv
// Shares one Avalon-MM PIO slave between the Nios data master (r0) and a NES-core status source (r1).
module nios_pio_arbiter
    import nios_pio_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              r0_valid,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_address,
    input  logic [DATA_W-1:0] r0_writedata,
    output logic              r0_waitrequest,
    output logic [DATA_W-1:0] r0_readdata,
    output logic              r0_readdatavalid,

    input  logic              r1_valid,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_address,
    input  logic [DATA_W-1:0] r1_writedata,
    output logic              r1_waitrequest,
    output logic [DATA_W-1:0] r1_readdata,
    output logic              r1_readdatavalid,

    output logic              chipselect,
    output logic              write_n,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata
);

    arb_state_e        state_q;
    logic              grant_q;
    logic              last_grant_q;
    logic              cs_q;
    logic              write_n_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        rvalid_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic [1:0]        req;
    logic [1:0]        win;

    assign req = {r1_valid, r0_valid};

    rr_arb2 u_rr_arb2 (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .grant_o      (win)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= REQ_CPU;
            last_grant_q <= LAST_GRANT_RST;
            cs_q         <= 1'b0;
            write_n_q    <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            rvalid_q     <= 2'b00;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            rvalid_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (win != 2'b00) begin
                        state_q <= ISSUE;
                        cs_q    <= 1'b1;
                        if (win[1]) begin
                            grant_q   <= REQ_HW;
                            addr_q    <= r1_address;
                            wdata_q   <= r1_writedata;
                            write_n_q <= ~r1_write;
                        end else begin
                            grant_q   <= REQ_CPU;
                            addr_q    <= r0_address;
                            wdata_q   <= r0_writedata;
                            write_n_q <= ~r0_write;
                        end
                    end
                end
                ISSUE: begin
                    state_q      <= IDLE;
                    cs_q         <= 1'b0;
                    write_n_q    <= 1'b1;
                    last_grant_q <= grant_q;
                    // readdata is combinational from address, so it is valid right now
                    if (write_n_q) begin
                        if (grant_q == REQ_HW) begin
                            rdata1_q    <= readdata;
                            rvalid_q[1] <= 1'b1;
                        end else begin
                            rdata0_q    <= readdata;
                            rvalid_q[0] <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign r0_waitrequest   = !((state_q == ISSUE) && (grant_q == REQ_CPU));
    assign r1_waitrequest   = !((state_q == ISSUE) && (grant_q == REQ_HW));
    assign r0_readdata      = rdata0_q;
    assign r1_readdata      = rdata1_q;
    assign r0_readdatavalid = rvalid_q[0];
    assign r1_readdatavalid = rvalid_q[1];

    assign chipselect = cs_q;
    assign write_n    = write_n_q;
    assign address    = addr_q;
    assign writedata  = wdata_q;

endmodule

// File: tb/tb_nios_pio_arbiter.sv
// Directed and randomized bench for nios_pio_arbiter with a transaction-level reference model.
module tb_nios_pio_arbiter;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        r0_valid, r0_write, r1_valid, r1_write;
    logic [1:0]  r0_address, r1_address;
    logic [31:0] r0_writedata, r1_writedata;
    logic        r0_waitrequest, r1_waitrequest;
    logic [31:0] r0_readdata, r1_readdata;
    logic        r0_readdatavalid, r1_readdatavalid;
    logic        chipselect, write_n;
    logic [1:0]  address;
    logic [31:0] writedata, readdata;

    always #5 clk = ~clk;

    nios_pio_arbiter #(.DATA_W(32), .ADDR_W(2)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .r0_valid         (r0_valid),
        .r0_write         (r0_write),
        .r0_address       (r0_address),
        .r0_writedata     (r0_writedata),
        .r0_waitrequest   (r0_waitrequest),
        .r0_readdata      (r0_readdata),
        .r0_readdatavalid (r0_readdatavalid),
        .r1_valid         (r1_valid),
        .r1_write         (r1_write),
        .r1_address       (r1_address),
        .r1_writedata     (r1_writedata),
        .r1_waitrequest   (r1_waitrequest),
        .r1_readdata      (r1_readdata),
        .r1_readdatavalid (r1_readdatavalid),
        .chipselect       (chipselect),
        .write_n          (write_n),
        .address          (address),
        .writedata        (writedata),
        .readdata         (readdata)
    );

    // 10-bit LED PIO: data register at address 0, other addresses read as zero
    logic [9:0]  pio_q = '0;
    logic [31:0] wlog[$];
    always @(posedge clk) begin
        if (chipselect && !write_n) begin
            wlog.push_back(writedata);
            if (address == 2'd0) pio_q <= writedata[9:0];
        end
    end
    assign readdata = (address == 2'd0) ? {22'b0, pio_q} : 32'b0;

    int cmp = 0;
    int mis = 0;
    int cyc = 0;
    int first_cs_cyc, first_rv1_cyc;

    txn_t q0[$], q1[$];
    bit   pres0, pres1;
    bit   gap;
    bit   man;
    bit   man_v0, man_v1;
    txn_t man_t0, man_t1;
    int   gq[$];

    // Reference model: "busy" means a transaction occupies the PIO this cycle
    bit          m_busy;
    int          m_gnt;
    int          m_last;
    txn_t        m_cmd;
    bit          m_rv[2];
    logic [31:0] m_rd[2];
    logic [9:0]  m_pio = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_gnt = 0; m_last = 1;
        m_rv[0] = 0; m_rv[1] = 0;
        m_rd[0] = '0; m_rd[1] = '0;
    endtask

    task automatic model_adv();
        int w;
        m_rv[0] = 0; m_rv[1] = 0;
        if (!m_busy) begin
            w = -1;
            if (r0_valid && r1_valid) w = (m_last == 0) ? 1 : 0;
            else if (r0_valid)        w = 0;
            else if (r1_valid)        w = 1;
            if (w >= 0) begin
                m_busy = 1;
                m_gnt  = w;
                if (w == 0) begin m_cmd.wr = r0_write; m_cmd.addr = r0_address; m_cmd.data = r0_writedata; end
                else        begin m_cmd.wr = r1_write; m_cmd.addr = r1_address; m_cmd.data = r1_writedata; end
            end
        end else begin
            m_busy = 0;
            m_last = m_gnt;
            if (m_cmd.wr) begin
                if (m_cmd.addr == 2'd0) m_pio = m_cmd.data[9:0];
            end else begin
                m_rv[m_gnt] = 1;
                m_rd[m_gnt] = (m_cmd.addr == 2'd0) ? {22'b0, m_pio} : 32'b0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("chipselect", chipselect, m_busy);
        chk("r0_waitrequest", r0_waitrequest, !(m_busy && m_gnt == 0));
        chk("r1_waitrequest", r1_waitrequest, !(m_busy && m_gnt == 1));
        chk("r0_readdatavalid", r0_readdatavalid, m_rv[0]);
        chk("r1_readdatavalid", r1_readdatavalid, m_rv[1]);
        chk("r0_readdata", r0_readdata, m_rd[0]);
        chk("r1_readdata", r1_readdata, m_rd[1]);
        if (m_busy) begin
            chk("write_n", write_n, !m_cmd.wr);
            chk("address", address, m_cmd.addr);
            chk("writedata", writedata, m_cmd.data);
        end
    endtask

    task automatic drive();
        if (man) begin
            r0_valid = man_v0; r0_write = man_t0.wr; r0_address = man_t0.addr; r0_writedata = man_t0.data;
            r1_valid = man_v1; r1_write = man_t1.wr; r1_address = man_t1.addr; r1_writedata = man_t1.data;
        end else begin
            if (!pres0 && q0.size() > 0 && (!gap || $urandom_range(1, 0) == 1)) pres0 = 1;
            if (!pres1 && q1.size() > 0 && (!gap || $urandom_range(1, 0) == 1)) pres1 = 1;
            r0_valid = pres0;
            r1_valid = pres1;
            if (pres0) begin r0_write = q0[0].wr; r0_address = q0[0].addr; r0_writedata = q0[0].data; end
            if (pres1) begin r1_write = q1[0].wr; r1_address = q1[0].addr; r1_writedata = q1[0].data; end
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        cyc++;
        drive();
        @(negedge clk);
        check_outputs();
        if (chipselect && first_cs_cyc < 0) first_cs_cyc = cyc;
        if (r1_readdatavalid && first_rv1_cyc < 0) first_rv1_cyc = cyc;
        if (pres0 && r0_waitrequest === 1'b0) begin void'(q0.pop_front()); pres0 = 0; gq.push_back(0); end
        if (pres1 && r1_waitrequest === 1'b0) begin void'(q1.pop_front()); pres1 = 0; gq.push_back(1); end
        model_adv();
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || pres0 || pres1 || m_busy || m_rv[0] || m_rv[1]) && n < budget) begin
            step();
            n++;
        end
        chk("cycle_budget", (n < budget), 1'b1);
        step();
        step();
    endtask

    task automatic check_reset_values();
        chk("rst_chipselect", chipselect, 1'b0);
        chk("rst_write_n", write_n, 1'b1);
        chk("rst_address", address, 2'd0);
        chk("rst_writedata", writedata, 32'd0);
        chk("rst_r0_rv", r0_readdatavalid, 1'b0);
        chk("rst_r1_rv", r1_readdatavalid, 1'b0);
        chk("rst_r0_rd", r0_readdata, 32'd0);
        chk("rst_r1_rd", r1_readdata, 32'd0);
        chk("rst_r0_wait", r0_waitrequest, 1'b1);
        chk("rst_r1_wait", r1_waitrequest, 1'b1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        q0.delete(); q1.delete(); pres0 = 0; pres1 = 0; man = 0;
        r0_valid = 0; r1_valid = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values();
        reset_n = 1'b1;
        cyc = 0; first_cs_cyc = -1; first_rv1_cyc = -1;
    endtask

    function automatic txn_t mk(input logic wr, input logic [1:0] a, input logic [31:0] d);
        txn_t t;
        t.wr = wr; t.addr = a; t.data = d;
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        r0_valid = 0; r0_write = 0; r0_address = 0; r0_writedata = 0;
        r1_valid = 0; r1_write = 0; r1_address = 0; r1_writedata = 0;
        gap = 0; man = 0; man_v0 = 0; man_v1 = 0;
        man_t0 = mk(0, 0, 0); man_t1 = mk(0, 0, 0);

        // Uncontended write: chipselect in cycle 2
        do_reset();
        q0.push_back(mk(1, 2'd0, 32'h2A5));
        run_until_done(50);
        chk("wr_cs_cycle", first_cs_cyc, 2);
        chk("pio_after_2A5", {22'b0, pio_q}, 32'h2A5);

        // r1 read returns in cycle 3
        q0.push_back(mk(1, 2'd0, 32'h155));
        run_until_done(50);
        cyc = 0; first_rv1_cyc = -1;
        q1.push_back(mk(0, 2'd0, 32'h0));
        run_until_done(50);
        chk("rd_rv_cycle", first_rv1_cyc, 3);
        chk("r1_rd_155", r1_readdata, 32'h155);

        // Unmapped read
        q1.push_back(mk(0, 2'd1, 32'h0));
        run_until_done(50);
        chk("r1_rd_unmapped", r1_readdata, 32'h0);

        // Continuous contention: strict alternation, starting with r0
        do_reset();
        gq.delete(); wlog.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1, 2'd0, 32'h100 + i));
            q1.push_back(mk(1, 2'd0, 32'h200 + i));
        end
        run_until_done(100);
        chk("alt_grant_count", gq.size(), 8);
        chk("alt_write_count", wlog.size(), 8);
        for (int i = 0; i < 8 && i < gq.size() && i < wlog.size(); i++) begin
            chk("alt_grant", gq[i], i % 2);
            chk("alt_wdata", wlog[i], ((i % 2) ? 32'h200 : 32'h100) + i / 2);
        end

        // Reset during ISSUE of a read
        q0.push_back(mk(0, 2'd0, 32'h0));
        step();
        @(posedge clk); #1;
        drive();
        #2;
        chk("issue_before_reset", chipselect, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_cs", chipselect, 1'b0);
        chk("async_rst_rv", r0_readdatavalid, 1'b0);
        model_reset();
        q0.delete(); pres0 = 0; r0_valid = 0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) step();
        gq.delete();
        q0.push_back(mk(1, 2'd0, 32'h011));
        q1.push_back(mk(1, 2'd0, 32'h022));
        run_until_done(50);
        chk("post_rst_first_grant", (gq.size() > 0) ? gq[0] : -1, 0);

        // Winner drops valid during ISSUE of a write
        wlog.delete();
        man = 1;
        man_v0 = 1; man_t0 = mk(1, 2'd0, 32'h3FF);
        man_v1 = 0;
        step();
        man_v0 = 0;
        repeat (3) step();
        man = 0;
        chk("drop_pio", {22'b0, pio_q}, 32'h3FF);
        chk("drop_wlog", wlog.size(), 1);

        // Randomized traffic against the model
        gap = 1;
        for (int i = 0; i < 24; i++) begin
            q0.push_back(mk($urandom_range(1, 0), $urandom_range(3, 0), $urandom));
            q1.push_back(mk($urandom_range(1, 0), $urandom_range(3, 0), $urandom));
        end
        run_until_done(3000);
        chk("rand_pio", {22'b0, pio_q}, {22'b0, m_pio});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end

endmodule
